exu_lsu: RTL and testbench

- Load/store unit directly downstream of the ALU address-generation stage in the execute unit.
- Consumes the computed memory address together with the read/write enables.
- Performs the data-bus transaction with a req/gnt/rvalid handshake, generating byte enables and store-data lanes, and sign/zero-extending load data.
- Returns load results to writeback and stalls the pipeline while a transaction is outstanding.

---
 rtl/exu_lsu.sv | 189 ++++++++++++++++++
 tb/tb_exu_lsu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_lsu.sv
// exu_lsu: execute-stage load/store unit. Takes one AGU request at a time,
// runs a req/gnt/rvalid data-bus transaction and returns extended load data
// to writeback, reporting misaligned, illegal and timed-out accesses.
module exu_lsu #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_ren,
   input  logic        i_mem_wen,
   input  logic [31:0] i_mem_addr,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   input  logic [4:0]  i_rd_idx,
   output logic        o_busy,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [3:0]  o_bus_be,
   output logic [31:0] o_bus_wdata,
   input  logic        i_bus_gnt,
   input  logic        i_bus_rvalid,
   input  logic [31:0] i_bus_rdata,
   output logic        o_wb_valid,
   output logic [4:0]  o_wb_rd,
   output logic [31:0] o_wb_data,
   output logic        o_st_done,
   output logic        o_err,
   output logic [1:0]  o_err_cause
);

   localparam logic [7:0] TO_LAST = TIMEOUT - 8'd1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [2:0]  r_funct3;
   logic [4:0]  r_rd;
   logic [7:0]  r_cnt;

   logic        w_accept, w_illegal, w_misal, w_go, w_to_hit;
   logic        w_wb_fire, w_st_fire, w_to_fire;
   logic [3:0]  w_be;
   logic [31:0] w_lane;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ld_data;

   // Status and bus strobes decode straight from registered state.
   assign o_busy      = (r_state != S_IDLE);
   assign o_bus_req   = (r_state == S_REQ);
   assign o_bus_we    = r_we;
   assign o_bus_addr  = {r_addr[31:2], 2'b00};
   assign o_bus_be    = r_be;
   assign o_bus_wdata = r_wdata;

   // Accept-time legality, alignment, byte-enable and store-lane decode.
   always_comb begin
      w_accept  = (r_state == S_IDLE) && (i_mem_ren || i_mem_wen);
      w_illegal = (i_mem_ren && i_mem_wen)
                || (i_mem_wen && !(i_funct3 == 3'b000 || i_funct3 == 3'b001 || i_funct3 == 3'b010))
                || (i_mem_ren && !(i_funct3 == 3'b000 || i_funct3 == 3'b001 || i_funct3 == 3'b010
                                   || i_funct3 == 3'b100 || i_funct3 == 3'b101));
      w_misal   = ((i_funct3[1:0] == 2'b01) && i_mem_addr[0])
                || ((i_funct3[1:0] == 2'b10) && (i_mem_addr[1:0] != 2'b00));
      w_go      = w_accept && !w_illegal && !w_misal;
      w_to_hit  = (TIMEOUT != 8'd0) && (r_cnt == TO_LAST);
      case (i_funct3[1:0])
         2'b00:   begin w_be = 4'b0001 << i_mem_addr[1:0]; w_lane = {4{i_wdata[7:0]}};  end
         2'b01:   begin w_be = 4'b0011 << i_mem_addr[1:0]; w_lane = {2{i_wdata[15:0]}}; end
         default: begin w_be = 4'b1111;                    w_lane = i_wdata;            end
      endcase
   end

   // Load lane extraction and sign/zero extension.
   always_comb begin
      case (r_addr[1:0])
         2'b00:   w_byte = i_bus_rdata[7:0];
         2'b01:   w_byte = i_bus_rdata[15:8];
         2'b10:   w_byte = i_bus_rdata[23:16];
         default: w_byte = i_bus_rdata[31:24];
      endcase
      w_half = r_addr[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
      case (r_funct3)
         3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ld_data = {24'd0, w_byte};
         3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
         3'b101:  w_ld_data = {16'd0, w_half};
         default: w_ld_data = i_bus_rdata;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and completion strobes; a handshake in the timeout cycle wins.
   always_comb begin
      w_state_nxt = r_state;
      w_wb_fire   = 1'b0;
      w_st_fire   = 1'b0;
      w_to_fire   = 1'b0;
      case (r_state)
         S_IDLE: if (w_go) w_state_nxt = S_REQ;
         S_REQ: begin
            if (i_bus_gnt) begin
               if (r_we) begin
                  w_st_fire   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else if (i_bus_rvalid) begin
                  w_wb_fire   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_WAIT_R;
               end
            end else if (w_to_hit) begin
               w_to_fire   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT_R: begin
            if (i_bus_rvalid) begin
               w_wb_fire   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_to_hit) begin
               w_to_fire   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Timeout counter: restarts on every state change, counts while busy.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                       r_cnt <= 8'd0;
      else if (w_state_nxt != r_state) r_cnt <= 8'd0;
      else if (r_state != S_IDLE)      r_cnt <= r_cnt + 8'd1;
   end

   // Request capture at accept.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_we     <= 1'b0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_be     <= 4'd0;
         r_funct3 <= 3'd0;
         r_rd     <= 5'd0;
      end else if (w_accept) begin
         r_we     <= i_mem_wen;
         r_addr   <= i_mem_addr;
         r_wdata  <= w_lane;
         r_be     <= w_be;
         r_funct3 <= i_funct3;
         r_rd     <= i_rd_idx;
      end
   end

   // Writeback, store-done and exception outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_wb_valid  <= 1'b0;
         o_wb_rd     <= 5'd0;
         o_wb_data   <= 32'd0;
         o_st_done   <= 1'b0;
         o_err       <= 1'b0;
         o_err_cause <= 2'b00;
      end else begin
         o_wb_valid <= w_wb_fire;
         o_st_done  <= w_st_fire;
         o_err      <= w_to_fire || (w_accept && (w_illegal || w_misal));
         if (w_wb_fire) begin
            o_wb_data <= w_ld_data;
            o_wb_rd   <= r_rd;
         end
         if (w_to_fire)                   o_err_cause <= 2'b10;
         else if (w_accept && w_illegal)  o_err_cause <= 2'b11;
         else if (w_accept && w_misal)    o_err_cause <= 2'b01;
      end
   end

endmodule

// File: tb/tb_exu_lsu.sv
// tb_exu_lsu: directed stimulus with a queue-based scoreboard; a negedge
// monitor pops expectations whenever the DUT presents a bus handshake,
// writeback, store completion or error.
module tb_exu_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_mem_ren, i_mem_wen;
   logic [31:0] i_mem_addr;
   logic [2:0]  i_funct3;
   logic [31:0] i_wdata;
   logic [4:0]  i_rd_idx;
   logic        o_busy, o_bus_req, o_bus_we;
   logic [31:0] o_bus_addr;
   logic [3:0]  o_bus_be;
   logic [31:0] o_bus_wdata;
   logic        i_bus_gnt, i_bus_rvalid;
   logic [31:0] i_bus_rdata;
   logic        o_wb_valid;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data;
   logic        o_st_done, o_err;
   logic [1:0]  o_err_cause;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_exp_t;

   bus_exp_t   q_bus[$];
   wb_exp_t    q_wb[$];
   int         q_st[$];
   logic [1:0] q_err[$];

   always #5 clk = ~clk;

   exu_lsu #(.TIMEOUT(8'd4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_mem_addr(i_mem_addr),
      .i_funct3(i_funct3), .i_wdata(i_wdata), .i_rd_idx(i_rd_idx),
      .o_busy(o_busy), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
      .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
      .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
      .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
      .o_st_done(o_st_done), .o_err(o_err), .o_err_cause(o_err_cause)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every DUT-presented event must match the head of its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (o_bus_req && i_bus_gnt) begin
            if (q_bus.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
            else begin
               bus_exp_t e;
               e = q_bus.pop_front();
               chk("bus_we",   32'(o_bus_we), 32'(e.we));
               chk("bus_addr", o_bus_addr,    e.addr);
               chk("bus_be",   32'(o_bus_be), 32'(e.be));
               if (e.we) chk("bus_wdata", o_bus_wdata, e.wdata);
            end
         end
         if (o_wb_valid) begin
            if (q_wb.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
            else begin
               wb_exp_t w;
               w = q_wb.pop_front();
               chk("wb_rd",   32'(o_wb_rd), 32'(w.rd));
               chk("wb_data", o_wb_data,    w.data);
            end
         end
         if (o_st_done) begin
            if (q_st.size() == 0) chk("st_unexpected", 32'd1, 32'd0);
            else void'(q_st.pop_front());
         end
         if (o_err) begin
            if (q_err.size() == 0) chk("err_unexpected", 32'd1, 32'd0);
            else chk("err_cause", 32'(o_err_cause), 32'(q_err.pop_front()));
         end
      end
   end

   task automatic issue(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd, input logic [4:0] rd);
      i_mem_ren = ren; i_mem_wen = wen; i_mem_addr = addr;
      i_funct3 = f3; i_wdata = wd; i_rd_idx = rd;
      @(posedge clk); #1;
      i_mem_ren = 1'b0; i_mem_wen = 1'b0;
   endtask

   // Drive the bus until the unit goes idle; gnt/rvalid fire at given cycle indices.
   task automatic run_bus(input string name, input int gnt_at, input int rv_at,
                          input logic [31:0] rdata, input int exp_busy, input int exp_req);
      int busy_n = 0;
      int req_n  = 0;
      int k      = 0;
      while (o_busy && k < 40) begin
         busy_n++;
         if (o_bus_req) req_n++;
         i_bus_gnt    = (k == gnt_at);
         i_bus_rvalid = (k == rv_at);
         i_bus_rdata  = rdata;
         @(posedge clk); #1;
         k++;
      end
      i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
      chk({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
      chk({name, "_req_cycles"},  32'(req_n),  32'(exp_req));
   endtask

   task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
      bus_exp_t e;
      e.we = we; e.addr = a; e.be = be; e.wdata = wd;
      q_bus.push_back(e);
   endtask

   task automatic push_wb(input logic [4:0] rd, input logic [31:0] d);
      wb_exp_t w;
      w.rd = rd; w.data = d;
      q_wb.push_back(w);
   endtask

   initial begin
      rst = 1'b1;
      i_mem_ren = 1'b0; i_mem_wen = 1'b0; i_mem_addr = 32'd0; i_funct3 = 3'd0;
      i_wdata = 32'd0; i_rd_idx = 5'd0;
      i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",      32'(o_busy),      32'd0);
      chk("rst_req",       32'(o_bus_req),   32'd0);
      chk("rst_bus_addr",  o_bus_addr,       32'd0);
      chk("rst_err_cause", 32'(o_err_cause), 32'd0);
      chk("rst_wb_data",   o_wb_data,        32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Word load, gnt on second req cycle, rvalid two cycles later.
      push_bus(1'b0, 32'h0000_1000, 4'b1111, 32'd0);
      push_wb(5'd5, 32'hDEAD_BEEF);
      issue(1'b1, 1'b0, 32'h0000_1000, 3'b010, 32'd0, 5'd5);
      run_bus("lw", 1, 3, 32'hDEAD_BEEF, 4, 2);

      // Byte/half loads with same-cycle gnt+rvalid.
      push_bus(1'b0, 32'h0000_2000, 4'b1000, 32'd0);
      push_wb(5'd6, 32'hFFFF_FF80);
      issue(1'b1, 1'b0, 32'h0000_2003, 3'b000, 32'd0, 5'd6);
      run_bus("lb", 0, 0, 32'h8011_2233, 1, 1);

      push_bus(1'b0, 32'h0000_2000, 4'b1000, 32'd0);
      push_wb(5'd6, 32'h0000_0080);
      issue(1'b1, 1'b0, 32'h0000_2003, 3'b100, 32'd0, 5'd6);
      run_bus("lbu", 0, 0, 32'h8011_2233, 1, 1);

      push_bus(1'b0, 32'h0000_2000, 4'b1100, 32'd0);
      push_wb(5'd7, 32'hFFFF_8011);
      issue(1'b1, 1'b0, 32'h0000_2002, 3'b001, 32'd0, 5'd7);
      run_bus("lh", 0, 0, 32'h8011_2233, 1, 1);

      push_bus(1'b0, 32'h0000_2000, 4'b0011, 32'd0);
      push_wb(5'd8, 32'h0000_2233);
      issue(1'b1, 1'b0, 32'h0000_2000, 3'b101, 32'd0, 5'd8);
      run_bus("lhu", 0, 0, 32'h8011_2233, 1, 1);

      // Halfword store, gnt after three wait cycles (lands on the timeout cycle).
      push_bus(1'b1, 32'h0000_3000, 4'b1100, 32'hABCD_ABCD);
      q_st.push_back(1);
      issue(1'b0, 1'b1, 32'h0000_3002, 3'b001, 32'h1234_ABCD, 5'd0);
      run_bus("sh", 3, -1, 32'd0, 4, 4);

      // Byte store lane replication.
      push_bus(1'b1, 32'h0000_3000, 4'b0010, 32'h5A5A_5A5A);
      q_st.push_back(1);
      issue(1'b0, 1'b1, 32'h0000_3001, 3'b000, 32'h0000_005A, 5'd0);
      run_bus("sb", 0, -1, 32'd0, 1, 1);

      // Misaligned and illegal requests: error only, no bus activity.
      q_err.push_back(2'b01);
      issue(1'b1, 1'b0, 32'h0000_4001, 3'b010, 32'd0, 5'd1);
      run_bus("lw_misal", 0, 0, 32'd0, 0, 0);

      q_err.push_back(2'b01);
      issue(1'b1, 1'b0, 32'h0000_4001, 3'b001, 32'd0, 5'd1);
      run_bus("lh_misal", 0, 0, 32'd0, 0, 0);

      q_err.push_back(2'b11);
      issue(1'b1, 1'b1, 32'h0000_4000, 3'b010, 32'd0, 5'd1);
      run_bus("ren_wen", 0, 0, 32'd0, 0, 0);

      q_err.push_back(2'b11);
      issue(1'b0, 1'b1, 32'h0000_4000, 3'b100, 32'd0, 5'd1);
      run_bus("sbu_illegal", 0, 0, 32'd0, 0, 0);

      // Timeout in REQ: no gnt at all.
      q_err.push_back(2'b10);
      issue(1'b1, 1'b0, 32'h0000_6000, 3'b010, 32'd0, 5'd2);
      run_bus("to_req", -1, -1, 32'd0, 4, 4);

      // gnt in the last allowed cycle wins over the timeout.
      push_bus(1'b0, 32'h0000_6000, 4'b1111, 32'd0);
      push_wb(5'd9, 32'h1234_5678);
      issue(1'b1, 1'b0, 32'h0000_6000, 3'b010, 32'd0, 5'd9);
      run_bus("gnt_last", 3, 5, 32'h1234_5678, 6, 4);

      // Timeout in WAIT_R: granted, rvalid never comes.
      push_bus(1'b0, 32'h0000_6004, 4'b1111, 32'd0);
      q_err.push_back(2'b10);
      issue(1'b1, 1'b0, 32'h0000_6004, 3'b010, 32'd0, 5'd3);
      run_bus("to_wait", 0, -1, 32'd0, 5, 1);

      // Reset while in WAIT_R; a stray rvalid afterwards must be ignored.
      push_bus(1'b0, 32'h0000_5000, 4'b1111, 32'd0);
      issue(1'b1, 1'b0, 32'h0000_5000, 3'b010, 32'd0, 5'd4);
      i_bus_gnt = 1'b1;
      @(posedge clk); #1;
      i_bus_gnt = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_busy",  32'(o_busy),      32'd0);
      chk("midrst_req",   32'(o_bus_req),   32'd0);
      chk("midrst_wbv",   32'(o_wb_valid),  32'd0);
      chk("midrst_cause", 32'(o_err_cause), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      i_bus_rvalid = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      i_bus_rvalid = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_busy", 32'(o_busy), 32'd0);

      push_bus(1'b0, 32'h0000_0000, 4'b1111, 32'd0);
      push_wb(5'd10, 32'h0BAD_F00D);
      issue(1'b1, 1'b0, 32'h0000_0000, 3'b010, 32'd0, 5'd10);
      run_bus("lw_after_rst", 0, 0, 32'h0BAD_F00D, 1, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("q_bus_left", 32'(q_bus.size()), 32'd0);
      chk("q_wb_left",  32'(q_wb.size()),  32'd0);
      chk("q_st_left",  32'(q_st.size()),  32'd0);
      chk("q_err_left", 32'(q_err.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
